dds_qw_lut_reader: RTL and testbench

DDS_QW_LUT_READER -- requirements
Module: dds_qw_lut_reader

---
 rtl/dds_qw_lut_reader.sv | 104 ++++++++++
 tb/tb_dds_qw_lut_reader.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/dds_qw_lut_reader.sv
// Phase accumulator and quarter-wave LUT reader: mirrors the address and
// negates the magnitude so a 512-entry first-quadrant table yields a full sine.
module dds_qw_lut_reader #(
    parameter int PHASE_W = 32
) (
    input  logic                      CLK,
    input  logic                      NSRST,
    input  logic                      EN,
    input  logic [PHASE_W-1:0]        FREQ_WORD,
    input  logic                      LOAD_FREQ,
    input  logic [PHASE_W-1:0]        PHASE_OFFSET,
    input  logic                      SYNC_CLR,
    output logic [8:0]                RADDR,
    output logic                      RDB,
    input  logic [17:0]               DO,
    output logic signed [18:0]        SINE,
    output logic                      SINE_VALID
);

    logic [PHASE_W-1:0] acc;
    logic [PHASE_W-1:0] freq_reg;

    logic [PHASE_W-1:0] phase_p0;
    logic [1:0]         quad_p0;
    logic [8:0]         addr_p0;

    logic               neg_p1;
    logic               neg_p2;
    logic               vld_p2;
    logic               neg_p3;
    logic               vld_p3;
    logic [17:0]        do_p3;

    // Zero-extend the table magnitude and negate it for the lower half-cycle.
    function automatic logic signed [18:0] apply_sign(input logic [17:0] mag,
                                                      input logic        neg);
        logic signed [18:0] ext;
        ext = $signed({1'b0, mag});
        return neg ? -ext : ext;
    endfunction

    // Stage 0: offset phase from the pre-update accumulator
    always_comb begin
        phase_p0 = acc + PHASE_OFFSET;
        quad_p0  = phase_p0[PHASE_W-1 -: 2];
        addr_p0  = quad_p0[0] ? ~phase_p0[PHASE_W-3 -: 9] : phase_p0[PHASE_W-3 -: 9];
    end

    generate
        if (PHASE_W > 11) begin : g_low_bits
            logic unused_phase_low;
            assign unused_phase_low = ^phase_p0[PHASE_W-12:0];
        end
    endgenerate

    // Accumulator, frequency register and stage 1 (address issue)
    always_ff @(posedge CLK) begin
        if (!NSRST) begin
            acc      <= '0;
            freq_reg <= '0;
            RADDR    <= '0;
            RDB      <= 1'b0;
            neg_p1   <= 1'b0;
        end else begin
            if (SYNC_CLR)
                acc <= '0;
            else if (EN)
                acc <= acc + freq_reg;
            if (LOAD_FREQ)
                freq_reg <= FREQ_WORD;
            RDB <= EN;
            if (EN) begin
                RADDR  <= addr_p0;
                neg_p1 <= quad_p0[1];
            end
        end
    end

    // Stage 2 (LUT read in flight), stage 3 (data captured), output stage
    always_ff @(posedge CLK) begin
        if (!NSRST) begin
            vld_p2     <= 1'b0;
            neg_p2     <= 1'b0;
            vld_p3     <= 1'b0;
            neg_p3     <= 1'b0;
            SINE       <= '0;
            SINE_VALID <= 1'b0;
        end else begin
            vld_p2     <= RDB;
            neg_p2     <= neg_p1;
            vld_p3     <= vld_p2;
            neg_p3     <= neg_p2;
            SINE_VALID <= vld_p3;
            if (vld_p3)
                SINE <= apply_sign(do_p3, neg_p3);
        end
    end

    always_ff @(posedge CLK) begin
        if (vld_p2)
            do_p3 <= DO;
    end

endmodule

// File: tb/tb_dds_qw_lut_reader.sv
// Randomized bench for dds_qw_lut_reader with a queue-based reference model
// and a synchronous-read LUT holding random magnitudes.
module tb_dds_qw_lut_reader;

    localparam int PW = 32;

    logic                 CLK = 1'b0;
    logic                 NSRST = 1'b0;
    logic                 EN = 1'b0;
    logic [PW-1:0]        FREQ_WORD = '0;
    logic                 LOAD_FREQ = 1'b0;
    logic [PW-1:0]        PHASE_OFFSET = '0;
    logic                 SYNC_CLR = 1'b0;
    logic [8:0]           RADDR;
    logic                 RDB;
    logic [17:0]          DO;
    logic signed [18:0]   SINE;
    logic                 SINE_VALID;

    dds_qw_lut_reader #(.PHASE_W(PW)) dut (
        .CLK(CLK), .NSRST(NSRST), .EN(EN), .FREQ_WORD(FREQ_WORD),
        .LOAD_FREQ(LOAD_FREQ), .PHASE_OFFSET(PHASE_OFFSET), .SYNC_CLR(SYNC_CLR),
        .RADDR(RADDR), .RDB(RDB), .DO(DO), .SINE(SINE), .SINE_VALID(SINE_VALID)
    );

    always #5 CLK = ~CLK;

    logic [17:0] lut [0:511];
    always @(posedge CLK) if (RDB) DO <= lut[RADDR];

    typedef struct { int due; int val; } ev_t;
    ev_t q[$];

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    longint      m_acc = 0;
    longint      m_freq = 0;
    int          exp_rdb = 0;
    int          exp_raddr = 0;
    int          exp_vld = 0;
    int          exp_sine = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s cyc=%0d got=0x%0h exp=0x%0h", tag, cyc, obs, expv);
        end
    endtask

    // One clock: drive inputs, advance the model at the edge, then compare.
    task automatic step(input logic en, input logic clr, input logic ld,
                        input logic [31:0] fw, input logic [31:0] off, input logic nrst);
        longint p;
        int quad, a, addr, mag;
        EN = en; SYNC_CLR = clr; LOAD_FREQ = ld; FREQ_WORD = fw;
        PHASE_OFFSET = off; NSRST = nrst;
        @(posedge CLK);
        cyc++;
        if (!nrst) begin
            m_acc = 0; m_freq = 0; q.delete();
            exp_rdb = 0; exp_raddr = 0; exp_sine = 0;
        end else begin
            exp_rdb = en ? 1 : 0;
            if (en) begin
                p    = (m_acc + longint'(off)) % (64'd1 << PW);
                quad = int'(p / (64'd1 << (PW-2)));
                a    = int'((p / (64'd1 << (PW-11))) % 512);
                addr = (quad % 2 == 1) ? 511 - a : a;
                mag  = int'(lut[addr]);
                exp_raddr = addr;
                q.push_back('{due: cyc + 3, val: (quad >= 2) ? ((1 << 19) - mag) % (1 << 19) : mag});
            end
            if (clr)      m_acc = 0;
            else if (en)  m_acc = (m_acc + m_freq) % (64'd1 << PW);
            if (ld)       m_freq = longint'(fw);
        end
        exp_vld = 0;
        if (q.size() > 0 && q[0].due == cyc) begin
            exp_vld  = 1;
            exp_sine = q[0].val;
            void'(q.pop_front());
        end
        #1;
        chk("rdb", {31'b0, RDB}, exp_rdb);
        chk("raddr", {23'b0, RADDR}, exp_raddr);
        chk("sine_valid", {31'b0, SINE_VALID}, exp_vld);
        chk("sine", {13'b0, SINE}, exp_sine);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    endtask

    initial begin
        for (int i = 0; i < 512; i++) lut[i] = 18'($urandom);
        lut[0] = 18'h12345;

        // Reset state
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        chk("reset_outs", {RADDR, RDB, SINE_VALID, SINE}, 32'h0);

        // Ramp across more than one full cycle, exercising the accumulator wrap
        step(1'b0, 1'b0, 1'b1, 32'h0020_0000, 32'h0, 1'b1);
        for (int i = 0; i < 2100; i++) step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        idle(4);

        // Mirror at the quarter-wave boundary with frozen phase
        step(1'b0, 1'b1, 1'b1, 32'h0, 32'h0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h4000_0000, 1'b1);
        chk("mirror_addr", {23'b0, RADDR}, 32'd511);
        idle(4);

        // Negation of a known magnitude
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h8000_0000, 1'b1);
        idle(3);
        chk("negate_sine", {13'b0, SINE}, 32'h6DCBB);
        chk("negate_vld", {31'b0, SINE_VALID}, 32'd1);
        idle(1);
        chk("negate_one_pulse", {31'b0, SINE_VALID}, 32'd0);

        // Clear coincident with an issued sample
        step(1'b0, 1'b0, 1'b1, 32'h1234_0000, 32'h0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        chk("clear_addr", {23'b0, RADDR}, 32'd0);
        idle(4);

        // Gapped EN pattern
        step(1'b0, 1'b0, 1'b1, $urandom, 32'h0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 32'h0, $urandom, 1'b1);
        step(1'b0, 1'b0, 1'b0, 32'h0, $urandom, 1'b1);
        step(1'b1, 1'b0, 1'b0, 32'h0, $urandom, 1'b1);
        step(1'b1, 1'b0, 1'b0, 32'h0, $urandom, 1'b1);
        step(1'b0, 1'b0, 1'b0, 32'h0, $urandom, 1'b1);
        idle(5);

        // Reset mid-stream with two samples in flight
        step(1'b1, 1'b0, 1'b0, 32'h0, $urandom, 1'b1);
        step(1'b1, 1'b0, 1'b0, 32'h0, $urandom, 1'b1);
        step(1'b1, 1'b1, 1'b1, $urandom, $urandom, 1'b0);
        chk("midreset_outs", {RADDR, RDB, SINE_VALID, SINE}, 32'h0);
        idle(5);
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        idle(4);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            step(($urandom % 4) != 0, ($urandom % 40) == 0, ($urandom % 25) == 0,
                 $urandom, $urandom, ($urandom % 150) != 0);
        end
        idle(5);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
